// File: rtl/usb_frame_encoder.sv
// Byte-stuffed frame encoder: SOF 0x7E, escaped payload, optional escaped checksum, EOF 0x7E.
// Define USB_FRAME_CHKSUM_EN to include the checksum stage (CHK/CHK_ESC2 and the accumulator).
module usb_frame_encoder #(
    parameter int MAX_LEN = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_rdy,
    output logic       tx_ack,
    input  logic [7:0] d,
    input  logic       last_byte,
    output logic       rdreq,
    input  logic       busy,
    output logic [7:0] q,
    output logic       q_asserted,
    output logic       pck_sent,
    output logic       err
);

    localparam logic [7:0]  FLAG     = 8'h7E;
    localparam logic [7:0]  ESC      = 8'h7D;
    localparam logic [7:0]  ESC_XOR  = 8'h20;
    localparam logic [10:0] LAST_CNT = 11'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, SOF, DATA, ESC2, CHK, CHK_ESC2, EOF, DONE
    } state_e;

`ifdef USB_FRAME_CHKSUM_EN
    localparam state_e POST_PAYLOAD = CHK;
`else
    localparam state_e POST_PAYLOAD = EOF;
`endif

    state_e      state_q;
    logic [10:0] cnt_q;
`ifdef USB_FRAME_CHKSUM_EN
    logic [7:0]  sum_q;
    logic        sum_esc;
    assign sum_esc = (sum_q == FLAG) || (sum_q == ESC);
`endif

    logic   d_esc;
    state_e byte_next;

    assign d_esc = (d == FLAG) || (d == ESC);
    // After a payload byte is consumed: checksum/EOF on last, forced EOF on over-length.
    assign byte_next = last_byte ? POST_PAYLOAD : ((cnt_q == LAST_CNT) ? EOF : DATA);

    // NOTE: the sink and source handshakes are same-cycle (busy gates the strobe, rdreq lets the
    // source advance on the next edge), so outputs are decoded from state and inputs, not registered.
    always_comb begin
        tx_ack     = 1'b0;
        rdreq      = 1'b0;
        q          = 8'h00;
        q_asserted = 1'b0;
        pck_sent   = 1'b0;
        err        = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: tx_ack = tx_rdy;
                SOF: begin
                    q          = FLAG;
                    q_asserted = !busy;
                end
                DATA: begin
                    q          = d_esc ? ESC : d;
                    q_asserted = !busy;
                    rdreq      = !busy && !d_esc;
                end
                ESC2: begin
                    q          = d ^ ESC_XOR;
                    q_asserted = !busy;
                    rdreq      = !busy;
                end
`ifdef USB_FRAME_CHKSUM_EN
                CHK: begin
                    q          = sum_esc ? ESC : sum_q;
                    q_asserted = !busy;
                end
                CHK_ESC2: begin
                    q          = sum_q ^ ESC_XOR;
                    q_asserted = !busy;
                end
`endif
                EOF: begin
                    q          = FLAG;
                    q_asserted = !busy;
                end
                DONE:    pck_sent = 1'b1;
                default: ;
            endcase
            err = rdreq && !last_byte && (cnt_q == LAST_CNT);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef USB_FRAME_CHKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (tx_rdy) state_q <= SOF;
                SOF: if (!busy) begin
                    state_q <= DATA;
                    cnt_q   <= '0;
`ifdef USB_FRAME_CHKSUM_EN
                    sum_q   <= '0;
`endif
                end
                DATA:     if (!busy) state_q <= d_esc ? ESC2 : byte_next;
                ESC2:     if (!busy) state_q <= byte_next;
`ifdef USB_FRAME_CHKSUM_EN
                CHK:      if (!busy) state_q <= sum_esc ? CHK_ESC2 : EOF;
                CHK_ESC2: if (!busy) state_q <= EOF;
`endif
                EOF:      if (!busy) state_q <= DONE;
                DONE:     state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
            if (rdreq) begin
                cnt_q <= cnt_q + 11'd1;
`ifdef USB_FRAME_CHKSUM_EN
                sum_q <= sum_q + d;
`endif
            end
        end
    end

endmodule
